// File: rtl/mips_pkg.sv
// Purpose : shared types and constants for the multiply/divide unit.
// Latency : n/a (types only).
// Backpressure: n/a.
package mips_pkg;

  // MDU operation codes; 3'b111 is reserved and treated as NOP.
  typedef enum logic [2:0] {
    NOP   = 3'b000,
    MULT  = 3'b001,
    MULTU = 3'b010,
    DIV   = 3'b011,
    DIVU  = 3'b100,
    MTHI  = 3'b101,
    MTLO  = 3'b110
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } mdu_state_t;

  // Cycles from the accepting edge until the edge that writes HI/LO.
  localparam int MDU_LATENCY = 33;

endpackage

// File: rtl/mdu_hilo_if.sv
// Purpose : request/result bundle between the execute stage and the MDU.
// Latency : n/a (wires only).
// Backpressure: requester must hold off while busy is high.
// Ports   : start/op/op1/op2 from the pipeline; busy/done/hi/lo back to it.
interface mdu_hilo_if
  import mips_pkg::*;
#(
  parameter int XLEN = 32
);
  logic            start;
  mdu_op_t         op;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (output start, op, op1, op2, input busy, done, hi, lo);
  modport slave  (input start, op, op1, op2, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_iter_step.sv
// Purpose : one radix-2 iteration, shift-add multiply or restoring divide.
// Latency : combinational.
// Backpressure: none.
// Ports   : is_div selects mode; part is the {hi,lo} working value, operand is
//           multiplicand or divisor; next is the updated working value and qbit
//           the quotient bit (always 0 when multiplying).
module mdu_iter_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] part,
  input  logic [XLEN-1:0]   operand,
  output logic [2*XLEN-1:0] next,
  output logic              qbit
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;

  always_comb begin
    // Multiply: low half holds the remaining multiplier bits, LSB first.
    // The carry out of the add becomes the new top bit after the right shift.
    sum    = {1'b0, part[2*XLEN-1:XLEN]} + (part[0] ? {1'b0, operand} : '0);
    // Divide: partial remainder shifted left by one, taking the next dividend bit.
    rem_sh = part[2*XLEN-1:XLEN-1];
    qbit   = 1'b0;
    next   = {sum, part[XLEN-1:1]};
    if (is_div) begin
      qbit = (rem_sh >= {1'b0, operand});
      // When subtracting, the true difference is below the divisor, so it fits
      // in XLEN bits and the wrapped XLEN-bit subtraction is exact.
      // The quotient bit slot is left 0 here and OR-ed in by the caller.
      next = {qbit ? (rem_sh[XLEN-1:0] - operand) : rem_sh[XLEN-1:0],
              part[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu_hilo.sv
// Purpose : iterative multiply/divide unit owning the architectural HI/LO registers.
// Latency : mult/div write HI/LO 33 edges after the accepting edge; MTHI/MTLO at that edge.
// Backpressure: busy high while iterating; any start during busy is dropped.
// Ports   : clk, reset (sync, active-high), bus (slave side of mdu_hilo_if).
module mdu_hilo
  import mips_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input logic        clk,
  input logic        reset,
  mdu_hilo_if.slave  bus
);

  localparam int CW = $clog2(ITER) + 1;

  mdu_state_t        state;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] part;
  logic [XLEN-1:0]   operand;
  logic [XLEN-1:0]   dividend;
  logic              is_div;
  logic              neg_q;
  logic              neg_r;
  logic              div_zero;
  logic              busy_q;
  logic              done_q;
  logic [XLEN-1:0]   hi_q;
  logic [XLEN-1:0]   lo_q;

  // Operand preparation at the accepting edge.
  logic              op_signed;
  logic              op_div;
  logic              op_iter;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   abs_a;
  logic [XLEN-1:0]   abs_b;

  always_comb begin
    op_signed = (bus.op == MULT) || (bus.op == DIV);
    op_div    = (bus.op == DIV)  || (bus.op == DIVU);
    op_iter   = op_div || (bus.op == MULT) || (bus.op == MULTU);
    a_neg     = op_signed && bus.op1[XLEN-1];
    b_neg     = op_signed && bus.op2[XLEN-1];
    // -0x80000000 wraps to 0x80000000, which is the correct unsigned magnitude.
    abs_a     = a_neg ? -bus.op1 : bus.op1;
    abs_b     = b_neg ? -bus.op2 : bus.op2;
  end

  logic [2*XLEN-1:0] step_next;
  logic              step_qbit;

  mdu_iter_step #(.XLEN(XLEN)) u_step (
    .is_div  (is_div),
    .part    (part),
    .operand (operand),
    .next    (step_next),
    .qbit    (step_qbit)
  );

  // Sign correction applied to the final working value in FIX.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   hi_new;
  logic [XLEN-1:0]   lo_new;

  always_comb begin
    prod_fix = neg_q ? -part : part;
    hi_new   = prod_fix[2*XLEN-1:XLEN];
    lo_new   = prod_fix[XLEN-1:0];
    if (is_div) begin
      if (div_zero) begin
        hi_new = dividend;
        lo_new = '1;
      end else begin
        lo_new = neg_q ? -part[XLEN-1:0] : part[XLEN-1:0];
        hi_new = neg_r ? -part[2*XLEN-1:XLEN] : part[2*XLEN-1:XLEN];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      part     <= '0;
      operand  <= '0;
      dividend <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (op_iter) begin
              // Divide keeps the dividend in the low half to be shifted out;
              // multiply keeps the multiplier there.
              part     <= {{XLEN{1'b0}}, op_div ? abs_a : abs_b};
              operand  <= op_div ? abs_b : abs_a;
              dividend <= bus.op1;
              is_div   <= op_div;
              neg_q    <= a_neg ^ b_neg;
              neg_r    <= a_neg;
              div_zero <= op_div && (bus.op2 == '0);
              cnt      <= '0;
              busy_q   <= 1'b1;
              state    <= CALC;
            end else if (bus.op == MTHI) begin
              hi_q <= bus.op1;
            end else if (bus.op == MTLO) begin
              lo_q <= bus.op1;
            end
          end
        end
        CALC: begin
          part <= step_next | {{(2*XLEN-1){1'b0}}, step_qbit};
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(ITER - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          hi_q   <= hi_new;
          lo_q   <= lo_new;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multi-cycle multiply/divide unit that owns the architectural HI/LO registers.
- Sits beside and downstream of the single-cycle ALU in the execute stage. It takes the same rs/rt operands and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Exposes `busy` so the pipeline controller stalls on MFHI/MFLO or a new mult/div until results are ready.
- HI/LO outputs feed the writeback mux for MFHI/MFLO.

Parameters:
- XLEN, 32, operand and HI/LO width.
- ITER, 32, iterations per mult/div; must equal XLEN.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled on a rising edge only when busy=0
- op  input  3  mdu_op_t operation code
- op1  input  XLEN  rs value (multiplicand / dividend / MTHI-MTLO source)
- op2  input  XLEN  rt value (multiplier / divisor)
- busy  output  1  iterative operation in flight
- done  output  1  one-cycle pulse: HI/LO just updated by a mult/div
- hi  output  XLEN  architectural HI register
- lo  output  XLEN  architectural LO register

Behaviour:
- Reset values: busy=0, done=0, hi=0, lo=0, FSM=IDLE, iteration counter=0. Reset takes priority over everything, including mid-operation: the operation is aborted and no partial HI/LO write occurs.
- FSM states: IDLE -> CALC -> FIX -> IDLE.
- IDLE, start=1, op in {MULT, MULTU, DIV, DIVU}:
  - Latch operands: absolute values for signed ops, plus result-sign flags.
  - counter=0, go to CALC.
- IDLE, start=1, op=MTHI: hi<=op1 at that edge; done stays 0; stay in IDLE.
- IDLE, start=1, op=MTLO: lo<=op1 at that edge; done stays 0; stay in IDLE.
- IDLE, start=1, op=NOP or reserved code: no effect.
- CALC: one iteration per cycle, exactly ITER cycles, then FIX.
  - Multiply: radix-2 shift-add into a 2*XLEN product.
  - Divide: restoring shift-subtract producing quotient and remainder.
- FIX, one cycle:
  - Apply sign correction.
  - Write hi/lo at the edge leaving FIX.
  - done=1 for the following cycle; go to IDLE.
- Timing: start sampled at edge E0 -> busy=1 for 33 cycles (E0..E33) -> hi/lo valid and done=1 after E33, with busy=0 in that same cycle.
- A new start is accepted in the done cycle.
- start while busy=1 is ignored, including MTHI/MTLO; the pipeline must stall instead.
- op1 and op2 are don't-care after the start edge.
- hi/lo hold their previous values throughout CALC and FIX.
- MULT: signed 64-bit product. hi = product[63:32], lo = product[31:0].
- MULTU: unsigned 64-bit product, same hi/lo split.
- DIV: lo = quotient truncated toward zero; hi = remainder, which takes the sign of the dividend.
- DIVU: unsigned quotient in lo, remainder in hi.
- Divide by zero, DIV or DIVU: lo=0xFFFFFFFF, hi=op1 (original dividend). Full latency still applies and there is no trap.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No trap.

Decomposition:
- Shared package `mips_pkg` holds:
  - mdu_op_t (3-bit): NOP=000, MULT=001, MULTU=010, DIV=011, DIVU=100, MTHI=101, MTLO=110, 111 reserved.
  - mdu_state_t: IDLE, CALC, FIX.
  - Constant MDU_LATENCY=33.
- One natural sub-module: `mdu_iter_step`, a combinational single-iteration step.
  - Mode select: multiply vs divide.
  - Inputs: partial remainder/product, operand.
  - Outputs: next partial value and quotient bit.
- FSM, counter, sign handling and HI/LO registers live in mdu_hilo.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 33 busy cycles done=1 with hi=0xFFFFFFFE, lo=0x00000001. MULT 0xFFFFFFFD x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- DIV 0xFFFFFFF9 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7 / 2 -> lo=3, hi=1.
- DIVU 0x64 / 0 -> lo=0xFFFFFFFF, hi=0x64. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 on consecutive cycles -> hi/lo update one edge after each, done never asserts, busy stays 0.
- Issue DIV; pulse start with MTLO 0xDEAD at cycle 5 of busy -> ignored; the final lo is the quotient and 0xDEAD never appears. In the done cycle, issue MULT 2x3 -> accepted, busy=1 for 33 cycles, then lo=6.
- Start MULT 0x10000 x 0x10000 after hi/lo were loaded via MTHI 0xAA/MTLO 0xBB; assert reset at busy cycle 10 -> next cycle busy=0, done=0, hi=0, lo=0, and no done pulse ever follows.
